// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the program counter and the
// instruction register, fetches words over a req/ack handshake and
// applies the control unit's next-PC decision once per instruction.
module fetch_unit #(
    parameter int              PC_W     = 5,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_target,
    input  logic               hlt,
    input  logic               stall,
    input  logic               resume,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Increment constant sized to the PC so the addition wraps modulo 2^PC_W.
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               next_state_s;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_next_s;
    logic [INSTR_W-1:0]   ir_r;
    logic [INSTR_W-1:0]   ir_next_s;

    // Next-state, next-PC and IR-capture decisions; everything holds unless
    // the current state explicitly changes it.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        ir_next_s    = ir_r;
        case (state_r)
            ST_IDLE: begin
                next_state_s = ST_FETCH;
            end
            ST_FETCH: begin
                // The address stays on pc until memory acknowledges.
                if (imem_ack) begin
                    ir_next_s    = imem_rdata;
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // Stall freezes the instruction and masks the control inputs,
                // so a halt requested during a stall waits for it to clear.
                if (stall) begin
                    next_state_s = ST_EXEC;
                end else if (hlt) begin
                    next_state_s = ST_HALT;
                end else if (pc_load) begin
                    pc_next_s    = pc_target;
                    next_state_s = ST_FETCH;
                end else if (pc_inc) begin
                    pc_next_s    = pc_r + PC_ONE;
                    next_state_s = ST_FETCH;
                end else begin
                    // No decision: refetch the same word.
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_next_s    = pc_r + PC_ONE;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC and instruction register; reset clears them immediately so
    // an in-flight request drops without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= {INSTR_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            ir_r    <= ir_next_s;
        end
    end

    // Handshake and status outputs are pure decodes of the state register.
    assign imem_req    = (state_r == ST_FETCH);
    assign instr_valid = (state_r == ST_EXEC);
    assign halted      = (state_r == ST_HALT);
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instruction = ir_r;

endmodule
